// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
interface if_stage_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i
  );
  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: up to two outstanding requests, 2-entry response FIFO,
// redirect with stale-response discard, and the IF-ID pipeline register.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
  parameter logic [31:0] DM_HALT_ADDR = 32'h1A11_0800,
  parameter logic [31:0] DM_EXC_ADDR  = 32'h1A11_0808
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        pc_set_i,
  input  logic [1:0]  pc_mux_i,
  input  logic [1:0]  exc_pc_mux_i,
  input  logic [4:0]  exc_cause_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_epc_i,
  if_stage_if.master  bus,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic        instr_fetch_err_o,
  output logic [31:0] pc_id_o,
  input  logic        id_in_ready_i,
  input  logic        instr_valid_clear_i,
  output logic        if_busy_o
);
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] pc;
  } fetch_t;

  logic [31:0] addr_q, pend_addr, resp_addr;
  logic [31:0] exc_target, raw_target, target;
  logic        held, stale;
  logic [1:0]  outstanding, discard_cnt, discard_nxt, fifo_count, push_pos;
  fetch_t      fifo_q [2];
  fetch_t      resp;
  logic        room, req, gnt, rv, rv_keep, pop_ok, load_fifo, load_byp, push;

  always_comb begin
    case (exc_pc_mux_i)
      2'b00:   exc_target = csr_mtvec_i & 32'hFFFF_FFFC;
      2'b01:   exc_target = (csr_mtvec_i & 32'hFFFF_FFFC) + {25'd0, exc_cause_i, 2'b00};
      2'b10:   exc_target = DM_HALT_ADDR;
      default: exc_target = DM_EXC_ADDR;
    endcase
    case (pc_mux_i)
      2'b00:   raw_target = BOOT_ADDR;
      2'b01:   raw_target = jump_target_i;
      2'b10:   raw_target = exc_target;
      default: raw_target = csr_epc_i;
    endcase
    target = raw_target & 32'hFFFF_FFFC;
  end

  // A raised request stays up until granted, independent of req_i and redirects.
  assign room      = ({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2;
  assign req       = !rst_i && (held || (req_i && room));
  assign gnt       = req && bus.instr_gnt_i;
  assign rv        = bus.instr_rvalid_i && (outstanding != 2'd0);
  assign rv_keep   = rv && (discard_cnt == 2'd0) && !pc_set_i;
  assign pop_ok    = !pc_set_i && !instr_valid_clear_i && (!instr_valid_id_o || id_in_ready_i);
  assign load_fifo = pop_ok && (fifo_count != 2'd0);
  assign load_byp  = pop_ok && (fifo_count == 2'd0) && rv_keep;
  assign push      = rv_keep && !load_byp;
  assign push_pos  = fifo_count - {1'b0, load_fifo};
  assign resp      = {bus.instr_rdata_i, bus.instr_err_i, resp_addr};

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = addr_q;
  assign if_busy_o        = req || (outstanding != 2'd0);

  // On redirect every response still owed is stale; a stale held request adds one when granted.
  always_comb begin
    if (pc_set_i)
      discard_nxt = outstanding + {1'b0, gnt} - {1'b0, rv};
    else
      discard_nxt = discard_cnt - {1'b0, rv && (discard_cnt != 2'd0)} + {1'b0, gnt && stale};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= BOOT_ADDR;
      pend_addr   <= BOOT_ADDR;
      resp_addr   <= BOOT_ADDR;
      held        <= 1'b0;
      stale       <= 1'b0;
      outstanding <= 2'd0;
      discard_cnt <= 2'd0;
    end else begin
      held        <= req && !bus.instr_gnt_i;
      outstanding <= outstanding + {1'b0, gnt} - {1'b0, rv};
      discard_cnt <= discard_nxt;
      if (gnt) begin
        stale  <= 1'b0;
        addr_q <= pc_set_i ? target : (stale ? pend_addr : addr_q + 32'd4);
      end else if (pc_set_i) begin
        if (req) begin
          stale     <= 1'b1;
          pend_addr <= target;
        end else begin
          addr_q <= target;
        end
      end
      if (pc_set_i)
        resp_addr <= target;
      else if (rv_keep)
        resp_addr <= resp_addr + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else if (pc_set_i) begin
      fifo_count <= 2'd0;
    end else begin
      if (load_fifo) fifo_q[0] <= fifo_q[1];
      if (push) fifo_q[push_pos[0]] <= resp;
      fifo_count <= fifo_count - {1'b0, load_fifo} + {1'b0, push};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_valid_id_o  <= 1'b0;
      instr_rdata_id_o  <= 32'd0;
      instr_fetch_err_o <= 1'b0;
      pc_id_o           <= 32'd0;
    end else if (pc_set_i || instr_valid_clear_i) begin
      instr_valid_id_o <= 1'b0;
    end else if (load_fifo) begin
      instr_valid_id_o <= 1'b1;
      {instr_rdata_id_o, instr_fetch_err_o, pc_id_o} <= fifo_q[0];
    end else if (load_byp) begin
      instr_valid_id_o <= 1'b1;
      {instr_rdata_id_o, instr_fetch_err_o, pc_id_o} <= resp;
    end else if (id_in_ready_i) begin
      instr_valid_id_o <= 1'b0;
    end
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0080, first fetch address after reset.
REQ-002 Parameter DM_HALT_ADDR, default 32'h1A11_0800, debug entry target.
REQ-003 Parameter DM_EXC_ADDR, default 32'h1A11_0808, debug-mode exception target.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  controller permits fetching.
REQ-007 pc_set_i  in  1  redirect fetch to address chosen by pc_mux_i.
REQ-008 pc_mux_i  in  2  00 boot, 01 jump, 10 exception, 11 xRET.
REQ-009 exc_pc_mux_i  in  2  00 mtvec base, 01 mtvec vectored IRQ, 10 DM_HALT_ADDR, 11 DM_EXC_ADDR.
REQ-010 exc_cause_i  in  5  IRQ index for vectored target.
REQ-011 jump_target_i  in  32  branch/jump target.
REQ-012 csr_mtvec_i  in  32  trap vector base.
REQ-013 csr_epc_i  in  32  mepc/depc selected upstream for xRET.
REQ-014 instr_req_o  out  1  memory request.
REQ-015 instr_addr_o  out  32  word-aligned request address.
REQ-016 instr_gnt_i  in  1  request accepted.
REQ-017 instr_rvalid_i  in  1  response valid, in order, at least 1 cycle after its grant.
REQ-018 instr_rdata_i  in  32  response data.
REQ-019 instr_err_i  in  1  response bus error, qualified by rvalid.
REQ-020 instr_valid_id_o  out  1  IF-ID register holds a valid instruction.
REQ-021 instr_rdata_id_o  out  32  IF-ID instruction word.
REQ-022 instr_fetch_err_o  out  1  IF-ID instruction had a bus error.
REQ-023 pc_id_o  out  32  IF-ID instruction address.
REQ-024 id_in_ready_i  in  1  ID consumes IF-ID contents this cycle.
REQ-025 instr_valid_clear_i  in  1  kill IF-ID contents.
REQ-026 if_busy_o  out  1  instr_req_o high or any request outstanding.

Function
REQ-027 Redirect target: boot=BOOT_ADDR; jump=jump_target_i; exception per exc_pc_mux_i (base={mtvec[31:2],00}; vectored=base+{exc_cause_i,00}; DM addrs); xRET=csr_epc_i; bits[1:0] forced 0; 32-bit wrap.
REQ-028 Requests: instr_req_o high when req_i && outstanding+fifo_count < 2; once high, instr_req_o and instr_addr_o held stable until instr_gnt_i, regardless of req_i or pc_set_i.
REQ-029 On grant: outstanding+1, fetch address +4 (wraps 32'hFFFF_FFFC -> 0); max outstanding 2.
REQ-030 Response: outstanding-1; if discard_cnt>0, drop and decrement discard_cnt; else push {rdata, err, pc} into 2-entry FIFO; pc tracked by response-address register, +4 per accepted response.
REQ-031 rvalid with outstanding=0 ignored; counters never underflow/overflow.
REQ-032 pc_set_i: same edge, FIFO flushed, instr_valid_id_o cleared, discard_cnt = responses still owed (incl. grant this cycle, excl. rvalid this cycle), fetch and response address = target; an ungranted held request keeps its old address and, once granted, adds 1 to discard_cnt.
REQ-033 pc_set_i with rvalid same cycle: response discarded.
REQ-034 IF-ID load when (!instr_valid_id_o || id_in_ready_i) && data available; FIFO empty -> bypass: rvalid in cycle N gives instr_valid_id_o=1 in cycle N+1.
REQ-035 id_in_ready_i with nothing available: instr_valid_id_o->0.
REQ-036 instr_valid_clear_i: instr_valid_id_o->0 next cycle, FIFO not popped that cycle; priority pc_set_i > instr_valid_clear_i > load.
REQ-037 req_i low: no new requests; outstanding responses still complete into FIFO.

Reset
REQ-038 During/after rst_i: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_id_o=0, instr_rdata_id_o=0, instr_fetch_err_o=0, pc_id_o=0, if_busy_o=0, counters/FIFO empty; reset mid-transaction abandons all outstanding responses (post-reset rvalid with outstanding=0 ignored).

Verification
REQ-039 Reset, req_i=1, gnt immediate, rvalid 1 cycle later, rdata=32'h00000013 -> addr 0x80,0x84 issued; valid_id next cycle, pc_id_o=0x80.
REQ-040 id_in_ready_i=0 with 2 responses buffered -> instr_req_o=0, IF-ID holds 0x80, FIFO full.
REQ-041 pc_set_i jump to 0x1000 with 2 outstanding -> both responses dropped; next valid pc_id_o=0x1000.
REQ-042 pc_set_i exception, exc_pc_mux_i=01, mtvec=0x2001, cause=7 -> first request 0x201C.
REQ-043 instr_err_i=1 on response for 0x84 -> instr_fetch_err_o=1 with pc_id_o=0x84.
REQ-044 rst_i pulsed with 1 outstanding, then stray rvalid -> ignored, first fetch from BOOT_ADDR.
